// File: rtl/pedal_mult_arbiter.sv
// Purpose: round-robin share of one signed Q1.15 16x16 multiplier among N_REQ effect blocks.
// Latency: request to Grant 1 cycle minimum; Grant to Result_valid exactly 2 cycles.
// Backpressure: none downstream; requesters hold Req/operands until their Grant pulse.
module pedal_mult_arbiter #(
  parameter int N_REQ = 4,  // 2..4 requesters
  parameter int W     = 16  // operand/result width, Q1.(W-1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*W-1:0] Op_a,
  input  logic [N_REQ*W-1:0] Op_b,
  output logic [N_REQ-1:0]   Grant,
  output logic [W-1:0]       Result,
  output logic               Result_valid,
  output logic [1:0]         Result_id,
  output logic               Busy
);

  localparam logic [W-1:0] MIN_Q = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_Q = {1'b0, {(W-1){1'b1}}};

  // Arbitration state: registered grant pulse, its index, and the priority pointer.
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [1:0]       ptr_q, ptr_d;

  // Arbiter scratch.
  logic [3:0] elig;
  logic [2:0] idx;
  logic       win_vld;
  logic [1:0] win_id;

  // Operand selection for the requester currently holding the grant.
  logic [W-1:0] sel_a, sel_b;

  // Stage 1: captured operands and owner id.
  logic                s1_vld_q;
  logic [1:0]          s1_id_q;
  logic signed [W-1:0] s1_a_q, s1_b_q;

  // Stage 2: scaled product and owner id, held until the next valid result.
  logic         s2_vld_q;
  logic [1:0]   s2_id_q;
  logic [W-1:0] s2_res_q, s2_res_d;

  logic signed [2*W-1:0] prod;
  logic                  sat;
  logic                  prod_unused;

  // Pick the first eligible requester scanning from ptr; the requester being
  // granted this cycle is masked so a held Req re-enters only after its pulse.
  always_comb begin
    elig             = '0;
    elig[N_REQ-1:0]  = Req & ~grant_q;
    win_vld          = 1'b0;
    win_id           = 2'd0;
    idx              = 3'd0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = 3'(ptr_q) + 3'(off);
      if (idx >= 3'(N_REQ)) begin
        idx = idx - 3'(N_REQ);
      end
      if (!win_vld && elig[idx[1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[1:0];
      end
    end
  end

  // Next grant pulse, its index, and the pointer advance past the winner.
  always_comb begin
    grant_d    = '0;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      grant_d[i] = win_vld && (win_id == 2'(i));
    end
    if (win_vld) begin
      grant_id_d = win_id;
      ptr_d      = (win_id == 2'(N_REQ - 1)) ? 2'd0 : win_id + 2'd1;
    end
  end

  // Route the granted requester's operands toward stage 1.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_a = Op_a[i*W +: W];
        sel_b = Op_b[i*W +: W];
      end
    end
  end

  // Full-width signed product; -1.0 * -1.0 is the single unrepresentable case.
  always_comb begin
    prod        = {{W{s1_a_q[W-1]}}, s1_a_q} * {{W{s1_b_q[W-1]}}, s1_b_q};
    sat         = (s1_a_q == MIN_Q) && (s1_b_q == MIN_Q);
    // Arithmetic shift by W-1 keeps bits [2W-2:W-1]; low bits truncate toward -inf.
    s2_res_d    = sat ? MAX_Q : prod[2*W-2:W-1];
    prod_unused = ^{prod[2*W-1], prod[W-2:0]};
  end

  // Arbiter registers; reset clears grants and returns priority to requester 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant_q    <= '0;
      grant_id_q <= 2'd0;
      ptr_q      <= 2'd0;
    end else begin
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

  // Stage 1 captures operands at the edge that ends the Grant cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_vld_q <= 1'b0;
      s1_id_q  <= 2'd0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else begin
      s1_vld_q <= |grant_q;
      if (|grant_q) begin
        s1_id_q <= grant_id_q;
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
      end
    end
  end

  // Stage 2 registers the scaled product; result and id hold between valids.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_vld_q <= 1'b0;
      s2_id_q  <= 2'd0;
      s2_res_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_id_q  <= s1_id_q;
        s2_res_q <= s2_res_d;
      end
    end
  end

  assign Grant        = grant_q;
  assign Result       = s2_res_q;
  assign Result_valid = s2_vld_q;
  assign Result_id    = s2_id_q;
  assign Busy         = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_pedal_mult_arbiter.sv
// Purpose: randomized and directed bench for pedal_mult_arbiter against a cycle-level reference.
// Latency: checks Grant one cycle after request and Result two cycles after Grant.
// Backpressure: stimulus follows the hold-until-Grant request protocol.
module tb_pedal_mult_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 16;

  logic               CLK   = 1'b0;
  logic               RESET = 1'b1;
  logic [N_REQ-1:0]   Req   = '0;
  logic [N_REQ*W-1:0] Op_a  = '0;
  logic [N_REQ*W-1:0] Op_b  = '0;
  logic [N_REQ-1:0]   Grant;
  logic [W-1:0]       Result;
  logic               Result_valid;
  logic [1:0]         Result_id;
  logic               Busy;

  pedal_mult_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Req         (Req),
    .Op_a        (Op_a),
    .Op_b        (Op_b),
    .Grant       (Grant),
    .Result      (Result),
    .Result_valid(Result_valid),
    .Result_id   (Result_id),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Q1.15 product by the textbook rule: full product, floor-divide by 2^15, one saturating case.
  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (a == 16'h8000 && b == 16'h8000) return 16'h7fff;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 15;
    return p[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: expected grant holder, pointer, operands in flight, visible result.
  int          m_gnt    = -1;
  int          m_ptr    = 0;
  bit          p1_v     = 1'b0;
  int          p1_id    = 0;
  logic [15:0] p1_a     = '0;
  logic [15:0] p1_b     = '0;
  bit          m_res_v  = 1'b0;
  logic [15:0] m_res    = '0;
  int          m_res_id = 0;

  always @(posedge CLK) begin : model
    logic [N_REQ-1:0]   rq;
    logic [N_REQ*W-1:0] oa, ob;
    bit                 rs;
    int                 win;
    int                 c;
    rq = Req;
    oa = Op_a;
    ob = Op_b;
    rs = RESET;
    if (rs) begin
      m_gnt    = -1;
      m_ptr    = 0;
      p1_v     = 1'b0;
      m_res_v  = 1'b0;
      m_res    = '0;
      m_res_id = 0;
    end else begin
      m_res_v = p1_v;
      if (p1_v) begin
        m_res    = qmul(p1_a, p1_b);
        m_res_id = p1_id;
      end
      p1_v = (m_gnt >= 0);
      if (p1_v) begin
        p1_id = m_gnt;
        p1_a  = oa[m_gnt*16 +: 16];
        p1_b  = ob[m_gnt*16 +: 16];
      end
      win = -1;
      for (int k = 0; k < N_REQ; k++) begin
        c = (m_ptr + k) % N_REQ;
        if (win < 0 && rq[c] && c != m_gnt) win = c;
      end
      m_gnt = win;
      if (win >= 0) m_ptr = (win + 1) % N_REQ;
    end
    #2;
    chk("grant", Grant, (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    chk("grant_onehot", 32'($countones(Grant) <= 1), 32'd1);
    chk("res_valid", Result_valid, m_res_v);
    chk("result", Result, m_res);
    chk("result_id", Result_id, m_res_id);
    chk("busy", Busy, p1_v | m_res_v);
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // One request on idx; returns cycles from raising Req to seeing Grant, checks the result.
  task automatic do_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge CLK);
    Op_a[idx*16 +: 16] = a;
    Op_b[idx*16 +: 16] = b;
    Req[idx]           = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge CLK);
      lat = n + 1;
      if (Grant[idx]) got = 1'b1;
    end
    chk("grant_seen", got, 1);
    Req[idx] = 1'b0;
    repeat (2) @(negedge CLK);
    chk("dir_valid", Result_valid, 1);
    chk("dir_result", Result, exp);
    chk("dir_id", Result_id, idx);
  endtask

  initial begin : watchdog
    #300000;
    failures++;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          lat;
    bit          gprev [3];
    logic [15:0] a, b;

    repeat (3) @(negedge CLK);
    chk("rst_grant", Grant, 0);
    chk("rst_result", Result, 0);
    chk("rst_valid", Result_valid, 0);
    chk("rst_id", Result_id, 0);
    chk("rst_busy", Busy, 0);
    RESET = 1'b0;

    // Single request and arithmetic corner cases.
    do_one(0, 16'h4000, 16'h4000, 16'h2000, lat);
    chk("first_latency", lat, 1);
    do_one(2, 16'h8000, 16'h8000, 16'h7fff, lat);
    do_one(2, 16'h8000, 16'h7fff, 16'h8001, lat);
    do_one(2, 16'hffff, 16'h0001, 16'hffff, lat);

    // Fairness with all four requesters held.
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      Op_a[i*16 +: 16] = rnd16();
      Op_b[i*16 +: 16] = rnd16();
    end
    @(negedge CLK);
    Req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("fair_grant", Grant, 32'd1 << (k % 4));
      if (k >= 2) begin
        chk("fair_valid", Result_valid, 1);
        chk("fair_id", Result_id, (k - 2) % 4);
      end
    end
    Req = 4'h0;

    // Pointer wrap after requester 3, then skip over an idle requester.
    do_reset();
    do_one(3, 16'h1234, 16'hc000, qmul(16'h1234, 16'hc000), lat);
    @(negedge CLK);
    Req = 4'b0101;
    @(negedge CLK);
    chk("wrap_g0", Grant, 4'b0001);
    @(negedge CLK);
    chk("wrap_g2", Grant, 4'b0100);
    Req = 4'b0000;

    // A request withdrawn before being served never sees a grant.
    @(negedge CLK);
    Req = 4'b0011;
    @(negedge CLK);
    chk("drop_g0", Grant, 4'b0001);
    Req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("drop_no_grant", Grant, 0);
    end

    // Reset right after two back-to-back grants flushes the pipeline.
    @(negedge CLK);
    Req = 4'b0011;
    @(negedge CLK);
    chk("mid_g1", Grant, 4'b0010);
    @(negedge CLK);
    chk("mid_g0", Grant, 4'b0001);
    Req = 4'b0000;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_valid", Result_valid, 0);
    chk("mid_busy", Busy, 0);
    chk("mid_grant", Grant, 0);
    Req = 4'b1010;
    @(negedge CLK);
    chk("mid_resume", Grant, 4'b0010);
    chk("mid_valid2", Result_valid, 0);
    Req = 4'b0000;
    repeat (4) @(negedge CLK);

    // Random traffic on requesters 0..2 following the hold-until-grant rule.
    for (int i = 0; i < 3; i++) gprev[i] = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (Req[i] && Grant[i]) begin
          // grant cycle: operands must stay put until the closing edge
        end else if (Req[i] && gprev[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            Req[i] = 1'b0;
          end else begin
            a = rnd16();
            b = rnd16();
            Op_a[i*16 +: 16] = a;
            Op_b[i*16 +: 16] = b;
          end
        end else if (Req[i]) begin
          if ($urandom_range(0, 19) == 0) Req[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          a = rnd16();
          b = rnd16();
          Op_a[i*16 +: 16] = a;
          Op_b[i*16 +: 16] = b;
          Req[i] = 1'b1;
        end
        gprev[i] = Grant[i];
      end
    end
    Req = 4'b0000;
    repeat (6) @(negedge CLK);
    chk("drain_busy", Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pedal_mult_arbiter.md
# pedal_mult_arbiter

Shares one pipelined signed 16×16 fractional multiplier among up to four effect blocks on the pedal board (tremolo, volume/gain, mixer, filter tap), so the board uses a single multiplier instead of one per effect. The block arbitrates requests round-robin, captures the winner's operands, and returns a Q1.15 product tagged with the requester index two cycles later. It sits between the effect modules and the multiplier resource, in the CLK domain that carries the 16-bit audio samples.

## Interface
- N_REQ, default 4: number of requesters, 2..4.
- W, default 16: operand and result width, Q1.15 signed.
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- Req  in  N_REQ  per-requester request level.
- Op_a  in  N_REQ*W  operand A per requester; requester i occupies bits [i*W +: W].
- Op_b  in  N_REQ*W  operand B per requester; same packing as Op_a.
- Grant  out  N_REQ  one-hot grant pulse, at most one bit set per cycle.
- Result  out  W  signed Q1.15 product.
- Result_valid  out  1  Result and Result_id are valid this cycle.
- Result_id  out  2  index of the requester that owns Result.
- Busy  out  1  one or more products are in flight in the pipeline.

## Operation
- Handshake:
  - Requester i raises Req[i] and holds Req[i], Op_a and Op_b stable until it sees Grant[i].
  - Grant[i] is a registered one-cycle pulse.
  - Operands are captured on the CLK edge that ends the Grant cycle.
  - The requester may drop Req[i] or present new operands in the cycle after Grant.
- Arbitration:
  - Round-robin with a priority pointer ptr.
  - The winner is the first requester with Req set, scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - After a grant to requester k, ptr becomes (k+1) mod N_REQ. ptr does not change if there is no grant.
- Request timing:
  - A grant is issued only for a requester whose Req is high in the cycle the grant is computed.
  - A request dropped before it is granted is simply not served; this is legal.
  - A requester that keeps Req high after its grant is treated as a new request. It re-enters arbitration the cycle after the Grant pulse and does not receive back-to-back grants while others are waiting.
- Throughput: one grant per cycle, and the pipeline accepts a new operation every cycle.
- Arithmetic:
  - Compute the full 32-bit signed product p = a*b.
  - Result = p >>> 15, an arithmetic shift that truncates toward −∞.
  - The only overflow case is 0x8000*0x8000, which saturates to 0x7FFF.
  - No other clipping is applied.
- Pipeline:
  - Stage 1 registers the operands and the id.
  - Stage 2 registers the product and the saturation result.
  - Each stage carries a valid bit.
- Busy is the OR of the stage valid bits.
- Reset:
  - Outputs: Grant=0, Result=0x0000, Result_valid=0, Result_id=0, Busy=0.
  - ptr=0, so requester 0 has first priority.
  - Asserting RESET mid-operation flushes both stages. No Result_valid is emitted for operations in flight, and no Grant is issued during reset.
  - Grants resume on the first non-reset cycle.
- Unused requester bits (index ≥ N_REQ) do not exist. Result_id is always < N_REQ.

## Timing
- Cycle t: Req[i] is sampled and arbitration runs.
- Cycle t+1: Grant[i]=1. Op_a[i] and Op_b[i] are sampled at the end of this cycle.
- Cycle t+3: Result_valid=1 with Result_id=i. Result holds until the next valid result; it is stable but meaningless when Result_valid=0.
- Latency:
  - Request to Grant: 1 cycle minimum.
  - Grant to Result_valid: 2 cycles, fixed.
- Simultaneous events:
  - Grant and Result_valid may coincide in the same cycle for different (or the same) requesters.
  - RESET takes priority over everything.
- Busy=1 from the cycle after the first Grant through the last Result_valid cycle.

## Test plan
- Single request: after reset, Req=0001, Op_a0=0x4000, Op_b0=0x4000.
  - Grant=0001 one cycle later.
  - Result=0x2000 with Result_id=0 two cycles after the Grant.
- Saturation and sign cases, all on requester 2:
  - 0x8000*0x8000 → 0x7FFF.
  - 0x8000*0x7FFF → 0x8001.
  - 0xFFFF*0x0001 → 0xFFFF, confirming truncation toward −∞.
- Fairness: Req=1111 held for 8 cycles.
  - Grants run 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Result_id follows the same sequence 2 cycles behind.
  - Result_valid is high every cycle once the pipeline fills.
- Pointer wrap and skip:
  - Grant requester 3, then raise Req=0101 → next Grant=0001, then 0100.
  - A requester dropped before being granted never receives a Grant.
- Reset mid-flight:
  - Assert RESET for 1 cycle on the cycle after two back-to-back Grants.
  - No Result_valid follows, Busy=0, ptr returns to 0, and with Req=1010 the next Grant is 0010.
- Back-to-back mixed traffic with random operands on 3 requesters for 1000 cycles:
  - Every Grant produces exactly one Result_valid with the matching id, 2 cycles later.
  - Results match the reference formula bit-exactly.
  - No two Grant bits are ever set in the same cycle.
